// File: rtl/aes50_rmii_pkg.sv
// Shared types and constants for the AES50 RMII framers.
// Holds the receive FSM states, the CRC-32 constants and the 2-bit CRC step.
package aes50_rmii_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData,
    StDiscard
  } rx_state_t;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  localparam logic [1:0] DIBIT_PRE   = 2'b01;
  localparam logic [1:0] DIBIT_SFD   = 2'b11;
  localparam logic [1:0] DIBIT_FALSE = 2'b10;

  // Reflected CRC-32 advanced by one dibit; d[0] is first on the wire.
  function automatic logic [31:0] crc32_d2_next(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      c = (c >> 1) ^ ((c[0] ^ d[i]) ? CRC32_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/aes50_crc32_d2.sv
// Registered CRC-32 (802.3, reflected) consuming one dibit per enabled cycle.
// Shared by the receive and transmit framers.
module aes50_crc32_d2
  import aes50_rmii_pkg::*;
(
  input  logic        sclk,
  input  logic        reset_n,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC32_INIT;
    end else if (en) begin
      crc_d = crc32_d2_next(crc_q, din);
    end
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/aes50_rmii_rx_framer.sv
// AES50 RMII receive framer: strips preamble/SFD, assembles LSB-first bytes,
// checks CRC-32 and emits a delimited byte stream with status and counters.
module aes50_rmii_rx_framer
  import aes50_rmii_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1536
) (
  input  logic        sclk,
  input  logic        reset_n,
  input  logic [2:0]  rxd_q,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_crc_ok,
  output logic        rx_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int unsigned CntW = $clog2(MAX_LEN + 2);
  localparam logic [CntW-1:0] OversizeCnt = CntW'(MAX_LEN + 1);
  localparam logic [CntW-1:0] MinCnt      = CntW'(MIN_LEN);

  logic [2:0]      samp_q, prev_q;
  logic [1:0]      primed_q;
  rx_state_t       state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [7:0]      shift_q, shift_d, held_q, held_d, byte_new;
  logic            have_held_q, have_held_d;
  logic            sof_pend_q, sof_pend_d;
  logic            valid_d, sof_d, eof_d, crc_ok_d, err_d;
  logic            crc_init, crc_en, crc_match;
  logic [31:0]     crc;
  logic            crs, carrier_end;
  logic [1:0]      dibit;

  // Two-deep sample pipe: prev_q is the dibit being decided, samp_q is the
  // look-ahead that tells a single-cycle CRS_DV toggle from a real carrier end.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      samp_q   <= '0;
      prev_q   <= '0;
      primed_q <= '0;
    end else begin
      samp_q   <= rxd_q;
      prev_q   <= samp_q;
      primed_q <= {primed_q[0], 1'b1};
    end
  end

  assign crs          = prev_q[2];
  assign dibit        = prev_q[1:0];
  assign carrier_end  = primed_q[1] && !prev_q[2] && !samp_q[2];
  assign byte_new     = {dibit, shift_q[7:2]};
  assign byte_cnt_inc = byte_cnt_q + 1'b1;
  assign crc_match    = (crc == CRC32_RESIDUE);

  aes50_crc32_d2 u_crc (
    .sclk    (sclk),
    .reset_n (reset_n),
    .init    (crc_init),
    .en      (crc_en),
    .din     (dibit),
    .crc     (crc)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    held_d      = held_q;
    have_held_d = have_held_q;
    sof_pend_d  = sof_pend_q;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    crc_ok_d    = 1'b0;
    err_d       = 1'b0;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (crs) begin
          if (dibit == DIBIT_PRE) begin
            state_d = StPreamble;
          end else if (dibit != 2'b00) begin
            state_d = StDiscard;
          end
        end
      end
      StPreamble: begin
        if (carrier_end) begin
          state_d = StIdle;
        end else if (dibit == DIBIT_SFD) begin
          state_d     = StData;
          crc_init    = 1'b1;
          byte_cnt_d  = '0;
          phase_d     = 2'd0;
          have_held_d = 1'b0;
          sof_pend_d  = 1'b1;
        end else if (dibit == DIBIT_FALSE) begin
          state_d = StDiscard;
        end
      end
      StData: begin
        if (carrier_end) begin
          state_d = StIdle;
          if (have_held_q) begin
            valid_d  = 1'b1;
            eof_d    = 1'b1;
            sof_d    = sof_pend_q;
            crc_ok_d = crc_match;
            err_d    = !crc_match || (phase_q != 2'd0) || (byte_cnt_q < MinCnt);
          end
        end else begin
          crc_en  = 1'b1;
          phase_d = phase_q + 2'd1;
          shift_d = byte_new;
          if (phase_q == 2'd3) begin
            byte_cnt_d = byte_cnt_inc;
            if (byte_cnt_inc == OversizeCnt) begin
              // Close the frame on the last in-range byte and drop the rest.
              valid_d = 1'b1;
              eof_d   = 1'b1;
              err_d   = 1'b1;
              sof_d   = sof_pend_q;
              state_d = StDiscard;
            end else begin
              held_d      = byte_new;
              have_held_d = 1'b1;
              if (have_held_q) begin
                valid_d    = 1'b1;
                sof_d      = sof_pend_q;
                sof_pend_d = 1'b0;
              end
            end
          end
        end
      end
      StDiscard: begin
        if (carrier_end) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // Reset lands in discard so a release during an active carrier waits it out.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StDiscard;
      phase_q     <= 2'd0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      held_q      <= '0;
      have_held_q <= 1'b0;
      sof_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      held_q      <= held_d;
      have_held_q <= have_held_d;
      sof_pend_q  <= sof_pend_d;
    end
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_sof    <= 1'b0;
      rx_eof    <= 1'b0;
      rx_crc_ok <= 1'b0;
      rx_err    <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      rx_valid  <= valid_d;
      rx_sof    <= sof_d;
      rx_eof    <= eof_d;
      rx_crc_ok <= crc_ok_d;
      rx_err    <= err_d;
      if (valid_d) begin
        rx_data <= held_q;
      end
      if (eof_d && (frame_cnt != 16'hFFFF)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (eof_d && err_d && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes50_rmii_rx_framer.sv
// Self-checking bench for aes50_rmii_rx_framer: a frame-level model predicts the
// byte stream and status, and a per-cycle monitor compares the DUT against it.
module tb_aes50_rmii_rx_framer;

  localparam int MinLen = 64;
  localparam int MaxLen = 1536;
  localparam logic [31:0] Residue = 32'hDEBB_20E3;

  logic        sclk = 1'b0;
  logic        reset_n;
  logic [2:0]  rxd_q;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err;
  logic [15:0] frame_cnt, err_cnt;

  always #10 sclk = ~sclk;

  aes50_rmii_rx_framer #(
    .MIN_LEN (MinLen),
    .MAX_LEN (MaxLen)
  ) dut (
    .sclk      (sclk),
    .reset_n   (reset_n),
    .rxd_q     (rxd_q),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sof    (rx_sof),
    .rx_eof    (rx_eof),
    .rx_crc_ok (rx_crc_ok),
    .rx_err    (rx_err),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       crc_ok;
    logic       err;
  } ev_t;

  int         n_checks = 0;
  int         n_fail = 0;
  ev_t        exp_q[$];
  int         exp_frames = 0;
  int         exp_errs = 0;
  logic [7:0] tx_bytes[$];
  logic [1:0] dib_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    logic fb;
    fb = c[0] ^ b;
    return (c >> 1) ^ (fb ? 32'hEDB8_8320 : 32'h0);
  endfunction

  function automatic logic [31:0] fcs_of();
    logic [31:0] c;
    c = '1;
    foreach (tx_bytes[i]) for (int k = 0; k < 8; k++) c = crc_step(c, tx_bytes[i][k]);
    return ~c;
  endfunction

  // Frame-level prediction from the dibits that follow the SFD.
  task automatic model_frame();
    int          nbytes, extra, last;
    logic [31:0] c;
    logic        ok;
    ev_t         e;
    nbytes = dib_q.size() / 4;
    extra  = dib_q.size() % 4;
    c = '1;
    foreach (dib_q[i]) begin
      c = crc_step(c, dib_q[i][0]);
      c = crc_step(c, dib_q[i][1]);
    end
    ok = (c == Residue);
    if (nbytes == 0) return;
    last = (nbytes > MaxLen) ? MaxLen : nbytes;
    e = '0;
    for (int i = 0; i < last; i++) begin
      e.data = {dib_q[4*i+3], dib_q[4*i+2], dib_q[4*i+1], dib_q[4*i]};
      e.sof  = (i == 0);
      e.eof  = (i == last - 1);
      if (nbytes > MaxLen) begin
        e.crc_ok = 1'b0;
        e.err    = e.eof;
      end else begin
        e.crc_ok = e.eof && ok;
        e.err    = e.eof && (!ok || extra != 0 || nbytes < MinLen);
      end
      exp_q.push_back(e);
    end
    if (exp_frames < 65535) exp_frames++;
    if (e.err && exp_errs < 65535) exp_errs++;
  endtask

  task automatic prep_frame(input bit add_fcs, input bit bad_fcs, input int extra);
    logic [31:0] f;
    if (add_fcs) begin
      f = fcs_of();
      if (bad_fcs) f[0] = ~f[0];
      for (int k = 0; k < 4; k++) tx_bytes.push_back(f[8*k +: 8]);
    end
    dib_q.delete();
    foreach (tx_bytes[i]) for (int k = 0; k < 4; k++) dib_q.push_back(tx_bytes[i][2*k +: 2]);
    for (int i = 0; i < extra; i++) dib_q.push_back(2'($urandom_range(0, 3)));
    model_frame();
  endtask

  task automatic drive(input logic crs, input logic [1:0] d);
    @(negedge sclk);
    rxd_q = {crs, d};
  endtask

  task automatic send_preamble();
    drive(1'b1, 2'b00);
    repeat (31) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
  endtask

  // toggle > 0 drops CRS_DV for one cycle on every toggle-th data dibit.
  task automatic xmit(input int toggle);
    send_preamble();
    foreach (dib_q[i]) begin
      if (toggle > 0 && i > 0 && i + 1 < dib_q.size() && (i % toggle) == 5)
        drive(1'b0, dib_q[i]);
      else
        drive(1'b1, dib_q[i]);
    end
    repeat (6) drive(1'b0, 2'b00);
    @(posedge sclk);
    #2;
  endtask

  task automatic end_checks(input string tag);
    check({tag, " model queue drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, " frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    check({tag, " err_cnt"}, 32'(err_cnt), 32'(exp_errs));
  endtask

  task automatic set_counting_payload();
    tx_bytes.delete();
    for (int i = 0; i < 60; i++) tx_bytes.push_back(8'(i));
  endtask

  task automatic set_random_payload(input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
  endtask

  // Per-cycle monitor, sampled 1 ns after the active edge.
  always @(posedge sclk) begin
    ev_t e;
    #1;
    if (reset_n) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          check("rx_valid with nothing expected", 32'(rx_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("rx_sof/eof/crc_ok/err", 32'({rx_sof, rx_eof, rx_crc_ok, rx_err}),
                32'({e.sof, e.eof, e.crc_ok, e.err}));
        end
      end else begin
        check("flags without rx_valid", 32'({rx_sof, rx_eof, rx_crc_ok, rx_err}), 32'd0);
      end
    end
  end

  initial begin
    string s;
    ev_t   e;
    reset_n = 1'b0;
    rxd_q   = '0;
    repeat (3) @(negedge sclk);
    #1;
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset flags", 32'({rx_sof, rx_eof, rx_crc_ok, rx_err}), 32'd0);
    check("reset counters", {frame_cnt, err_cnt}, 32'd0);
    @(negedge sclk);
    reset_n = 1'b1;
    repeat (5) drive(1'b0, 2'b00);

    // Pin the model's CRC against the published check value.
    s = "123456789";
    tx_bytes.delete();
    for (int i = 0; i < s.len(); i++) tx_bytes.push_back(s[i]);
    check("model crc32(123456789)", fcs_of(), 32'hCBF4_3926);

    // Good frame.
    set_counting_payload();
    prep_frame(1'b1, 1'b0, 0);
    check("model good size", 32'(exp_q.size()), 32'd64);
    check("model good first", 32'({exp_q[0].data, exp_q[0].sof}), 32'h001);
    check("model good last", 32'({exp_q[63].eof, exp_q[63].crc_ok, exp_q[63].err}), 32'b110);
    xmit(0);
    check("good frame_cnt", 32'(frame_cnt), 32'd1);
    end_checks("good");

    // Bad CRC.
    set_counting_payload();
    prep_frame(1'b1, 1'b1, 0);
    xmit(0);
    check("bad crc err_cnt", 32'(err_cnt), 32'd1);
    end_checks("bad crc");

    // CRS_DV toggling inside the payload.
    set_counting_payload();
    prep_frame(1'b1, 1'b0, 0);
    xmit(37);
    end_checks("toggle");

    // Runt with valid CRC.
    set_random_payload(36);
    prep_frame(1'b1, 1'b0, 0);
    e = exp_q[exp_q.size() - 1];
    check("model runt status", 32'({e.eof, e.crc_ok, e.err}), 32'b111);
    xmit(0);
    end_checks("runt");

    // Alignment error: one trailing dibit.
    set_counting_payload();
    prep_frame(1'b1, 1'b0, 1);
    xmit(0);
    end_checks("align");

    // Oversize then a normal frame.
    set_random_payload(1600);
    prep_frame(1'b0, 1'b0, 0);
    check("model oversize size", 32'(exp_q.size()), 32'd1536);
    xmit(0);
    end_checks("oversize");
    set_counting_payload();
    prep_frame(1'b1, 1'b0, 0);
    xmit(0);
    end_checks("after oversize");

    // False carrier, then a normal frame.
    drive(1'b1, 2'b10);
    repeat (20) drive(1'b1, 2'($urandom_range(0, 3)));
    repeat (6) drive(1'b0, 2'b00);
    @(posedge sclk);
    #2;
    end_checks("false carrier");
    set_counting_payload();
    prep_frame(1'b1, 1'b0, 0);
    xmit(0);
    end_checks("after false carrier");

    // SFD straight into carrier loss, and a 1-byte frame.
    tx_bytes.delete();
    prep_frame(1'b0, 1'b0, 0);
    xmit(0);
    end_checks("empty");
    set_random_payload(1);
    prep_frame(1'b0, 1'b0, 0);
    xmit(0);
    end_checks("one byte");

    // Reset mid-payload with CRS_DV held high through release.
    set_random_payload(20);
    dib_q.delete();
    foreach (tx_bytes[i]) for (int k = 0; k < 4; k++) dib_q.push_back(tx_bytes[i][2*k +: 2]);
    for (int i = 0; i < 9; i++) begin
      e = '0;
      e.data = tx_bytes[i];
      e.sof  = (i == 0);
      exp_q.push_back(e);
    end
    send_preamble();
    for (int i = 0; i < 43; i++) drive(1'b1, dib_q[i]);
    @(negedge sclk);
    reset_n = 1'b0;
    repeat (2) @(negedge sclk);
    #1;
    check("mid reset outputs", 32'({rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err}), 32'd0);
    check("mid reset counters", {frame_cnt, err_cnt}, 32'd0);
    check("bytes before reset", 32'(exp_q.size()), 32'd0);
    exp_frames = 0;
    exp_errs   = 0;
    @(negedge sclk);
    reset_n = 1'b1;
    rxd_q   = {1'b1, dib_q[43]};
    for (int i = 44; i < 80; i++) drive(1'b1, dib_q[i]);
    repeat (6) drive(1'b0, 2'b00);
    @(posedge sclk);
    #2;
    end_checks("after reset");
    set_counting_payload();
    prep_frame(1'b1, 1'b0, 0);
    xmit(0);
    check("post reset frame_cnt", 32'(frame_cnt), 32'd1);
    end_checks("post reset frame");

    // Randomized frames.
    for (int n = 0; n < 20; n++) begin
      set_random_payload(int'($urandom_range(1, 120)));
      prep_frame(1'b1, $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      xmit(($urandom_range(0, 1) == 1) ? 29 : 0);
      end_checks("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
